// File: rtl/axi_burst_read_responder_pkg.sv
// -----------------------------------------------------------------------------
// axi_burst_read_responder_pkg
// Shared definitions for the burst read responder: FSM state encoding, the
// only supported beat size, and the bubble LFSR seed / tap mask plus its
// single-step helper.
// -----------------------------------------------------------------------------
package axi_burst_read_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_e;

  localparam logic [2:0] RSIZE_WORD = 3'd2;
  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  // Fibonacci taps 8,6,5,4 (1-based) -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS  = 8'b1011_1000;

  // One LFSR shift: feedback is the XOR of the tapped bits, shifted in at bit 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axi_burst_read_responder_resp_word_ram.sv
// -----------------------------------------------------------------------------
// resp_word_ram
// Simple dual-port word RAM: one write port, one read port, synchronous read.
// A read and a write to the same word in one cycle return the old contents
// (read-first). The read register holds its value when re is low and is
// cleared by reset; the array itself is never cleared.
// Ports:
//   clk, rstn       clock, synchronous active-low reset (read register only)
//   we, waddr, wdata  write port
//   re, raddr         read port (address sampled when re is high)
//   rdata             registered read data
// -----------------------------------------------------------------------------
module resp_word_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Sampling the array with a non-blocking read gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else if (re) begin
      rd_data_q <= mem_q[raddr];
    end
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/axi_burst_read_responder.sv
// -----------------------------------------------------------------------------
// axi_burst_read_responder
// Main-memory model for cache refills. Accepts one burst read request, waits
// LATENCY cycles, then streams rlen+1 32-bit beats from an internal word RAM.
// A side init port loads the RAM at any time.
//
// Build option: define BURST_RESP_BUBBLE_EN to insert pseudo-random one-cycle
// bubbles between beats (8-bit Fibonacci LFSR); undefined gives strictly
// back-to-back beats.
//
// Ports:
//   clk, rstn              clock, synchronous active-low reset
//   rvalid                 request valid, held high by the initiator until the last beat
//   raddr, rlen, rsize     burst start byte address, beats-1, log2 bytes per beat
//   rready, rdata, rlast   beat strobe, beat data, final-beat flag
//   init_we/addr/wdata     RAM init write port
//   busy                   high whenever the FSM is not IDLE
//   err                    one-cycle pulse: unsupported rsize on accept, or abort
// -----------------------------------------------------------------------------
module axi_burst_read_responder
  import axi_burst_read_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rvalid,
  output logic              rready,
  input  logic [31:0]       raddr,
  output logic [31:0]       rdata,
  output logic              rlast,
  input  logic [2:0]        rsize,
  input  logic [7:0]        rlen,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [31:0]       init_wdata,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [7:0]        LAT_INIT = 8'(LATENCY);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_q, beat_d;
  logic [7:0]        lat_q, lat_d;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] beat_offs;
  logic              bubble_now;
  logic              bubble_take;

`ifdef BURST_RESP_BUBBLE_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       bubble_q, bubble_d;
`endif

  // Byte-offset bits and address bits above the RAM depth are ignored.
  logic unused_raddr_bits;
  assign unused_raddr_bits = ^{raddr[31:ADDR_W+2], raddr[1:0]};

  // Truncation to ADDR_W makes the word address wrap modulo the RAM depth.
  assign beat_offs = ADDR_W'(beat_q);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
    end
  end

`ifdef BURST_RESP_BUBBLE_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr_q   <= LFSR_SEED;
      bubble_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      bubble_q <= bubble_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    rd_en       = 1'b0;
    rd_addr     = base_q;
    rready      = 1'b0;
    rlast       = 1'b0;
    err         = 1'b0;
    bubble_take = 1'b0;
`ifdef BURST_RESP_BUBBLE_EN
    lfsr_d      = lfsr_q;
    bubble_d    = bubble_q;
    bubble_now  = bubble_q;
`else
    bubble_now  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (rvalid) begin
          base_d  = raddr[ADDR_W+1:2];
          len_d   = rlen;
          beat_d  = 8'd0;
          lat_d   = LAT_INIT;
          state_d = WAIT;
          // Unsupported sizes are flagged but still served as word beats.
          err     = (rsize != RSIZE_WORD);
`ifdef BURST_RESP_BUBBLE_EN
          bubble_d = 1'b0;
`endif
        end
      end

      WAIT: begin
        if (!rvalid) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          lat_d = lat_q - 8'd1;
          // Prefetch the base word so it is on rdata in the first beat cycle.
          if (lat_q == 8'd1) begin
            rd_en   = 1'b1;
            rd_addr = base_q;
            state_d = BURST;
          end
        end
      end

      BURST: begin
`ifdef BURST_RESP_BUBBLE_EN
        lfsr_d = lfsr_step(lfsr_q);
`endif
        if (!rvalid) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (bubble_now) begin
          // Bubble cycle: the read of the next word was deferred to here so
          // rdata keeps the previous beat for the whole bubble.
`ifdef BURST_RESP_BUBBLE_EN
          bubble_d = 1'b0;
`endif
          rd_en   = 1'b1;
          rd_addr = base_q + beat_offs;
        end else begin
          rready = 1'b1;
          rlast  = (beat_q == len_q);
          if (rlast) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
`ifdef BURST_RESP_BUBBLE_EN
            bubble_take = lfsr_q[0];
            bubble_d    = lfsr_q[0];
`endif
            if (!bubble_take) begin
              rd_en   = 1'b1;
              rd_addr = base_q + beat_offs + ADDR_ONE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  resp_word_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (init_we),
    .waddr (init_addr),
    .wdata (init_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_axi_burst_read_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_burst_read_responder
// Directed bench for axi_burst_read_responder (ADDR_W=8, LATENCY=4).
// Cycle numbering: edge t is the edge that accepts the request; capture slot
// c holds the outputs seen in the cycle after edge t+c.
// -----------------------------------------------------------------------------
module tb_axi_burst_read_responder;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rvalid;
  logic          rready;
  logic [31:0]   raddr;
  logic [31:0]   rdata;
  logic          rlast;
  logic [2:0]    rsize;
  logic [7:0]    rlen;
  logic          init_we;
  logic [AW-1:0] init_addr;
  logic [31:0]   init_wdata;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  logic        cap_rready [0:31];
  logic        cap_rlast  [0:31];
  logic        cap_busy   [0:31];
  logic        cap_err    [0:31];
  logic [31:0] cap_rdata  [0:31];
  logic        acc_err;

  always #5 clk = ~clk;

  axi_burst_read_responder #(
    .ADDR_W  (AW),
    .LATENCY (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rvalid     (rvalid),
    .rready     (rready),
    .raddr      (raddr),
    .rdata      (rdata),
    .rlast      (rlast),
    .rsize      (rsize),
    .rlen       (rlen),
    .init_we    (init_we),
    .init_addr  (init_addr),
    .init_wdata (init_wdata),
    .busy       (busy),
    .err        (err)
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic init_word(input logic [AW-1:0] a, input logic [31:0] d);
    init_we    = 1'b1;
    init_addr  = a;
    init_wdata = d;
    @(posedge clk); #1;
    init_we    = 1'b0;
  endtask

  // Issues one request, captures ncyc cycles after acceptance. rvalid drops
  // right after the edge that retires the last beat, or after drop_after
  // beats when drop_after is non-zero (abort).
  task automatic run_burst(input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input int ncyc,
                           input int drop_after);
    int  beats;
    bit  drop;
    beats  = 0;
    drop   = 1'b0;
    rvalid = 1'b1;
    raddr  = a;
    rlen   = len;
    rsize  = size;
    @(negedge clk);
    acc_err = err;
    @(posedge clk); #1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      cap_rready[c] = rready;
      cap_rlast[c]  = rlast;
      cap_busy[c]   = busy;
      cap_err[c]    = err;
      cap_rdata[c]  = rdata;
      if (rready) beats++;
      if ((rready && rlast) || (drop_after != 0 && beats == drop_after)) drop = 1'b1;
      @(posedge clk); #1;
      if (drop) rvalid = 1'b0;
    end
    rvalid = 1'b0;
    $display("burst addr=%h len=%0d size=%0d beats=%0d acc_err=%b", a, len, size, beats, acc_err);
  endtask

  task automatic test_reset();
    rstn = 1'b0; rvalid = 1'b0; raddr = '0; rsize = 3'd2; rlen = '0;
    init_we = 1'b0; init_addr = '0; init_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b expected 0", rready); end
    n_checks++; if (rlast !== 1'b0)  begin n_fail++; $display("FAIL reset_rlast: got %b expected 0", rlast); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    @(posedge clk); #1;
    rstn = 1'b1;
    $display("reset released");
  endtask

`ifndef BURST_RESP_BUBBLE_EN
  task automatic test_basic();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;
    for (int i = 0; i < 4; i++) init_word(AW'(8'h10 + i), exp_w[i]);
    run_burst(32'h40, 8'd3, 3'd2, 10, 0);
    n_checks++; if (acc_err !== 1'b0) begin n_fail++; $display("FAIL basic_acc_err: got %b expected 0", acc_err); end
    for (int c = 0; c < 10; c++) begin
      n_checks++; if (cap_rready[c] !== (c >= 4 && c <= 7)) begin n_fail++; $display("FAIL basic_rready c=%0d: got %b expected %b", c, cap_rready[c], (c >= 4 && c <= 7)); end
      n_checks++; if (cap_rlast[c] !== (c == 7)) begin n_fail++; $display("FAIL basic_rlast c=%0d: got %b expected %b", c, cap_rlast[c], (c == 7)); end
      n_checks++; if (cap_busy[c] !== (c <= 7)) begin n_fail++; $display("FAIL basic_busy c=%0d: got %b expected %b", c, cap_busy[c], (c <= 7)); end
      n_checks++; if (cap_err[c] !== 1'b0) begin n_fail++; $display("FAIL basic_err c=%0d: got %b expected 0", c, cap_err[c]); end
      if (c >= 4 && c <= 7) begin
        n_checks++; if (cap_rdata[c] !== exp_w[c-4]) begin n_fail++; $display("FAIL basic_rdata c=%0d: got %h expected %h", c, cap_rdata[c], exp_w[c-4]); end
      end
    end
    n_checks++; if (cap_rdata[9] !== 32'h44) begin n_fail++; $display("FAIL basic_rdata_hold: got %h expected 00000044", cap_rdata[9]); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'hA0; exp_w[1] = 32'hA1; exp_w[2] = 32'hA2; exp_w[3] = 32'hA3;
    init_word(8'd254, exp_w[0]);
    init_word(8'd255, exp_w[1]);
    init_word(8'd0,   exp_w[2]);
    init_word(8'd1,   exp_w[3]);
    run_burst(32'h3F8, 8'd3, 3'd2, 10, 0);
    for (int c = 4; c < 8; c++) begin
      n_checks++; if (cap_rready[c] !== 1'b1) begin n_fail++; $display("FAIL wrap_rready c=%0d: got %b expected 1", c, cap_rready[c]); end
      n_checks++; if (cap_rdata[c] !== exp_w[c-4]) begin n_fail++; $display("FAIL wrap_rdata c=%0d: got %h expected %h", c, cap_rdata[c], exp_w[c-4]); end
    end
    n_checks++; if (cap_rready[8] !== 1'b0) begin n_fail++; $display("FAIL wrap_end_rready: got %b expected 0", cap_rready[8]); end
  endtask

  task automatic test_single_beat();
    int nrdy;
    run_burst(32'h44, 8'd0, 3'd2, 8, 0);
    nrdy = 0;
    for (int c = 0; c < 8; c++) if (cap_rready[c] === 1'b1) nrdy++;
    n_checks++; if (nrdy != 1) begin n_fail++; $display("FAIL single_count: got %0d beats expected 1", nrdy); end
    n_checks++; if (cap_rready[4] !== 1'b1 || cap_rlast[4] !== 1'b1) begin n_fail++; $display("FAIL single_flags: got rready=%b rlast=%b expected 1 1", cap_rready[4], cap_rlast[4]); end
    n_checks++; if (cap_rdata[4] !== 32'h22) begin n_fail++; $display("FAIL single_rdata: got %h expected 00000022", cap_rdata[4]); end
    n_checks++; if (cap_busy[5] !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b expected 0", cap_busy[5]); end
  endtask

  task automatic test_bad_size();
    run_burst(32'h40, 8'd3, 3'd3, 10, 0);
    n_checks++; if (acc_err !== 1'b1) begin n_fail++; $display("FAIL size_acc_err: got %b expected 1", acc_err); end
    n_checks++; if (cap_err[0] !== 1'b0) begin n_fail++; $display("FAIL size_err_pulse: got %b expected 0 after accept", cap_err[0]); end
    for (int c = 4; c < 8; c++) begin
      n_checks++; if (cap_rready[c] !== 1'b1 || cap_rdata[c] !== 32'h11 * (c - 3)) begin n_fail++; $display("FAIL size_beat c=%0d: got rready=%b rdata=%h expected 1 %h", c, cap_rready[c], cap_rdata[c], 32'h11 * (c - 3)); end
    end
  endtask

  task automatic test_abort_and_reset();
    run_burst(32'h40, 8'd3, 3'd2, 10, 1);
    n_checks++; if (cap_rready[4] !== 1'b1 || cap_rdata[4] !== 32'h11) begin n_fail++; $display("FAIL abort_beat0: got rready=%b rdata=%h expected 1 00000011", cap_rready[4], cap_rdata[4]); end
    n_checks++; if (cap_err[5] !== 1'b1) begin n_fail++; $display("FAIL abort_err: got %b expected 1", cap_err[5]); end
    for (int c = 5; c < 10; c++) begin
      n_checks++; if (cap_rready[c] !== 1'b0) begin n_fail++; $display("FAIL abort_rready c=%0d: got %b expected 0", c, cap_rready[c]); end
    end
    n_checks++; if (cap_busy[6] !== 1'b0 || cap_err[6] !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b err=%b expected 0 0", cap_busy[6], cap_err[6]); end

    // Reset in the middle of beat 1.
    rvalid = 1'b1; raddr = 32'h40; rlen = 8'd3; rsize = 3'd2;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rready !== 1'b1 || rdata !== 32'h22) begin n_fail++; $display("FAIL rst_mid_beat: got rready=%b rdata=%h expected 1 00000022", rready, rdata); end
    rstn = 1'b0; rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if ({rready, rlast, busy, err} !== 4'b0000 || rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_clear: got rready=%b rlast=%b busy=%b err=%b rdata=%h expected all 0", rready, rlast, busy, err, rdata); end
    rstn = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-burst applied");
    run_burst(32'h40, 8'd3, 3'd2, 10, 0);
    for (int c = 4; c < 8; c++) begin
      n_checks++; if (cap_rready[c] !== 1'b1 || cap_rdata[c] !== 32'h11 * (c - 3)) begin n_fail++; $display("FAIL rst_after_beat c=%0d: got rready=%b rdata=%h expected 1 %h", c, cap_rready[c], cap_rdata[c], 32'h11 * (c - 3)); end
    end
    n_checks++; if (cap_rlast[7] !== 1'b1 || cap_busy[8] !== 1'b0) begin n_fail++; $display("FAIL rst_after_end: got rlast=%b busy=%b expected 1 0", cap_rlast[7], cap_busy[8]); end
  endtask
`else
  task automatic test_bubble();
    logic [31:0] exp_w [4];
    logic        exp_rdy [0:31];
    logic [31:0] exp_dat [0:31];
    logic [7:0]  m;
    logic        bub;
    int          k;
    int          nrdy;
    exp_w[0] = 32'h55; exp_w[1] = 32'h66; exp_w[2] = 32'h77; exp_w[3] = 32'h88;
    for (int i = 0; i < 4; i++) init_word(AW'(8'h20 + i), exp_w[i]);
    // Reference: LFSR from seed, one step per BURST cycle; bubble after a
    // non-last beat whose cycle sees lfsr bit 0 set.
    for (int c = 0; c < 32; c++) begin exp_rdy[c] = 1'b0; exp_dat[c] = 32'h0; end
    m = 8'hA5; bub = 1'b0; k = 0;
    for (int c = 4; c < 32 && k < 4; c++) begin
      if (bub) begin
        bub = 1'b0;
        exp_dat[c] = exp_w[k-1];
      end else begin
        exp_rdy[c] = 1'b1;
        exp_dat[c] = exp_w[k];
        if (k != 3 && m[0]) bub = 1'b1;
        k++;
      end
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end
    run_burst(32'h80, 8'd3, 3'd2, 16, 0);
    nrdy = 0;
    for (int c = 0; c < 16; c++) begin
      if (cap_rready[c] === 1'b1) nrdy++;
      n_checks++; if (cap_rready[c] !== exp_rdy[c]) begin n_fail++; $display("FAIL bubble_rready c=%0d: got %b expected %b", c, cap_rready[c], exp_rdy[c]); end
      if (c >= 4 && exp_dat[c] != 32'h0) begin
        n_checks++; if (cap_rdata[c] !== exp_dat[c]) begin n_fail++; $display("FAIL bubble_rdata c=%0d: got %h expected %h", c, cap_rdata[c], exp_dat[c]); end
      end
    end
    n_checks++; if (nrdy != 4) begin n_fail++; $display("FAIL bubble_count: got %0d beats expected 4", nrdy); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef BURST_RESP_BUBBLE_EN
    test_basic();
    test_wrap();
    test_single_beat();
    test_bad_size();
    test_abort_and_reset();
`else
    test_bubble();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
